// File: rtl/proc_sequencer.sv
// proc_sequencer: initiator side of the processor instruction interface.
//   Holds a 2**AW x 14 program memory and issues one instruction per processor
//   operation: pulses w, holds F/Rx/Ry/Data until Done, captures BusWires on Done.
// Ports:
//   Clock, Reset          - rising-edge clock, synchronous active-high reset
//   Start, LastAddr       - run program from address 0 to LastAddr (IDLE only)
//   ProgLoad/Addr/Word    - program memory write port (IDLE only)
//   Done, BusWires        - completion strobe and result bus from proc
//   w, F, Rx, Ry, Data    - instruction strobe and fields to proc
//   PC, Result            - current instruction address, last captured bus value
//   Busy, Finished, Error - status: running, end-of-program pulse, sticky timeout
// Optional build macro PROC_SEQ_TIMEOUT_EN: aborts a WAIT lasting TIMEOUT cycles
//   and raises Error; without it Error is tied low and WAIT never times out.
// Latency: Start -> first w is 1 cycle; Done -> next w is 1 cycle.
module proc_sequencer #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          ProgLoad,
  input  logic [AW-1:0] ProgAddr,
  input  logic [13:0]   ProgWord,
  input  logic [AW-1:0] LastAddr,
  input  logic          Done,
  input  logic [7:0]    BusWires,
  output logic          w,
  output logic [1:0]    F,
  output logic [1:0]    Rx,
  output logic [1:0]    Ry,
  output logic [7:0]    Data,
  output logic [AW-1:0] PC,
  output logic [7:0]    Result,
  output logic          Busy,
  output logic          Finished,
  output logic          Error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t          state_q;
  logic [13:0]     mem_q [2**AW];
  logic [13:0]     instr_q;
  logic            w_q;
  logic            busy_q;
  logic            fin_q;
  logic [AW-1:0]   pc_q;
  logic [AW-1:0]   last_q;
  logic [7:0]      result_q;

  logic            prog_wr_d;
  logic [AW-1:0]   pc_inc_d;
  logic [AW-1:0]   fetch_addr_d;
  logic [13:0]     fetch_word_d;

  // Memory is only writable while idle; it is deliberately not cleared by Reset.
  assign prog_wr_d = (state_q == S_IDLE) && ProgLoad && !Reset;

  always_ff @(posedge Clock) begin
    if (prog_wr_d) begin
      mem_q[ProgAddr] <= ProgWord;
    end
  end

  // The word fetched on an edge is either address 0 (Start) or PC+1 (advance).
  // A write landing on the fetched address in the same cycle is forwarded so a
  // Start that coincides with a load of word 0 sees the new word.
  assign pc_inc_d     = pc_q + 1'b1;
  assign fetch_addr_d = (state_q == S_IDLE) ? '0 : pc_inc_d;
  assign fetch_word_d = (prog_wr_d && (ProgAddr == fetch_addr_d)) ? ProgWord
                                                                   : mem_q[fetch_addr_d];

`ifdef PROC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt_q;
  logic          error_q;
  assign Error = error_q;
`else
  logic unused_timeout;
  assign Error          = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      w_q      <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      last_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
`ifdef PROC_SEQ_TIMEOUT_EN
      wcnt_q   <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      // w and Finished are single-cycle pulses.
      w_q   <= 1'b0;
      fin_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            pc_q    <= '0;
            last_q  <= LastAddr;
            instr_q <= fetch_word_d;
            w_q     <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
`ifdef PROC_SEQ_TIMEOUT_EN
            error_q <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          // Done here belongs to no instruction of ours and is ignored.
          state_q <= S_WAIT;
`ifdef PROC_SEQ_TIMEOUT_EN
          wcnt_q  <= '0;
`endif
        end
        S_WAIT: begin
          // Fields stay frozen: mvi reads Data at proc T1, after w has dropped.
          if (Done) begin
            result_q <= BusWires;
            if (pc_q == last_q) begin
              fin_q   <= 1'b1;
              state_q <= S_FIN;
            end else begin
              pc_q    <= pc_inc_d;
              instr_q <= fetch_word_d;
              w_q     <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
`ifdef PROC_SEQ_TIMEOUT_EN
          else if (wcnt_q == CW'(TIMEOUT - 1)) begin
            // Abort leaves PC on the faulting instruction for inspection.
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wcnt_q  <= wcnt_q + 1'b1;
          end
`endif
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign w        = w_q;
  assign F        = instr_q[13:12];
  assign Rx       = instr_q[11:10];
  assign Ry       = instr_q[9:8];
  assign Data     = instr_q[7:0];
  assign PC       = pc_q;
  assign Result   = result_q;
  assign Busy     = busy_q;
  assign Finished = fin_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer; the bench plays the processor role,
// answering each w with Done after a per-instruction latency.
module tb_proc_sequencer;
  localparam int AW = 4;

  logic          Clock = 1'b0;
  logic          Reset, Start, ProgLoad, Done;
  logic [AW-1:0] ProgAddr, LastAddr;
  logic [13:0]   ProgWord;
  logic [7:0]    BusWires;
  logic          w, Busy, Finished, Error;
  logic [1:0]    F, Rx, Ry;
  logic [7:0]    Data, Result;
  logic [AW-1:0] PC;

  int checks = 0;
  int errors = 0;

  proc_sequencer #(.AW(AW), .TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .ProgLoad(ProgLoad),
    .ProgAddr(ProgAddr), .ProgWord(ProgWord), .LastAddr(LastAddr),
    .Done(Done), .BusWires(BusWires), .w(w), .F(F), .Rx(Rx), .Ry(Ry),
    .Data(Data), .PC(PC), .Result(Result), .Busy(Busy),
    .Finished(Finished), .Error(Error)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [13:0] wd);
    ProgLoad = 1'b1; ProgAddr = a; ProgWord = wd;
    tick;
    ProgLoad = 1'b0;
  endtask

  task automatic start_prog(input logic [AW-1:0] last);
    LastAddr = last; Start = 1'b1;
    tick;
    Start = 1'b0;
  endtask

  // Entered in the ISSUE cycle. mode 1: spurious Done during ISSUE;
  // mode 2: Start/ProgLoad/LastAddr disturbance while waiting.
  task automatic serve(input string nm, input logic [AW-1:0] pc, input logic [13:0] word,
                       input int lat, input logic [7:0] bus, input bit last, input int mode);
    checks++;
    if (w !== 1'b1 || PC !== pc || {F, Rx, Ry, Data} !== word) begin
      errors++;
      $display("FAIL %s issue: w=%b PC=%0d word=%h, expected w=1 PC=%0d word=%h",
               nm, w, PC, {F, Rx, Ry, Data}, pc, word);
    end
    if (mode == 1) begin Done = 1'b1; BusWires = 8'hEE; end
    tick;
    Done = 1'b0;
    checks++;
    if (w !== 1'b0 || Busy !== 1'b1 || {F, Rx, Ry, Data} !== word || PC !== pc ||
        Finished !== 1'b0 || Result === 8'hEE) begin
      errors++;
      $display("FAIL %s wait: w=%b Busy=%b PC=%0d word=%h Result=%h Fin=%b, expected w=0 Busy=1 PC=%0d word=%h Result!=EE Fin=0",
               nm, w, Busy, PC, {F, Rx, Ry, Data}, Result, Finished, pc, word);
    end
    if (mode == 2) begin
      Start = 1'b1; ProgLoad = 1'b1; ProgAddr = pc; ProgWord = 14'h3FFF; LastAddr = '0;
    end
    for (int i = 1; i < lat; i++) begin
      tick;
      Start = 1'b0; ProgLoad = 1'b0;
    end
    checks++;
    if (w !== 1'b0 || {F, Rx, Ry, Data} !== word) begin
      errors++;
      $display("FAIL %s hold: w=%b word=%h, expected w=0 word=%h", nm, w, {F, Rx, Ry, Data}, word);
    end
    Done = 1'b1; BusWires = bus;
    tick;
    Done = 1'b0; Start = 1'b0; ProgLoad = 1'b0;
    checks++;
    if (Result !== bus || (last ? (Finished !== 1'b1 || w !== 1'b0)
                                : (w !== 1'b1 || Finished !== 1'b0))) begin
      errors++;
      $display("FAIL %s done: Result=%h w=%b Fin=%b, expected Result=%h w=%b Fin=%b",
               nm, Result, w, Finished, bus, !last, last);
    end
  endtask

  task automatic check_idle(input string nm, input logic [AW-1:0] pc, input logic [7:0] res);
    tick;
    checks++;
    if (Busy !== 1'b0 || Finished !== 1'b0 || w !== 1'b0 || PC !== pc || Result !== res) begin
      errors++;
      $display("FAIL %s idle: Busy=%b Fin=%b w=%b PC=%0d Result=%h, expected 0 0 0 PC=%0d Result=%h",
               nm, Busy, Finished, w, PC, Result, pc, res);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({w, F, Rx, Ry, Data, PC, Result, Busy, Finished, Error} !== '0) begin
      errors++;
      $display("FAIL %s: w=%b F=%b Rx=%b Ry=%b Data=%h PC=%0d Result=%h Busy=%b Fin=%b Err=%b, expected all 0",
               nm, w, F, Rx, Ry, Data, PC, Result, Busy, Finished, Error);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick;
    tick;
    check_zero("reset");
    Reset = 1'b0;
  endtask

  task automatic test_single;
    load(0, 14'h0005);
    start_prog(0);
    serve("single", 0, 14'h0005, 3, 8'h05, 1, 0);
    check_idle("single", 0, 8'h05);
  endtask

  task automatic test_program;
    load(0, 14'h0005);   // mvi R0,0x05
    load(1, 14'h0403);   // mvi R1,0x03
    load(2, 14'h2100);   // add R0,R1
    load(3, 14'h3100);   // sub R0,R1
    start_prog(3);
    serve("prog0", 0, 14'h0005, 1, 8'h05, 0, 0);
    serve("prog1", 1, 14'h0403, 1, 8'h03, 0, 0);
    serve("prog2", 2, 14'h2100, 3, 8'h08, 0, 1);
    serve("prog3", 3, 14'h3100, 3, 8'h05, 1, 0);
    check_idle("prog", 3, 8'h05);
  endtask

  task automatic test_busy_ignore;
    start_prog(3);
    serve("busy0", 0, 14'h0005, 1, 8'h05, 0, 2);
    serve("busy1", 1, 14'h0403, 2, 8'h03, 0, 2);
    serve("busy2", 2, 14'h2100, 3, 8'h08, 0, 0);
    serve("busy3", 3, 14'h3100, 3, 8'h05, 1, 0);
    check_idle("busy", 3, 8'h05);
  endtask

  task automatic test_reset_mid;
    start_prog(3);
    serve("rst0", 0, 14'h0005, 1, 8'h05, 0, 0);
    tick;               // now in WAIT of the second instruction
    Reset = 1'b1;
    tick;
    check_zero("reset_mid");
    Reset = 1'b0;
    start_prog(3);
    serve("rerun0", 0, 14'h0005, 1, 8'h05, 0, 0);
    serve("rerun1", 1, 14'h0403, 1, 8'h03, 0, 0);
    serve("rerun2", 2, 14'h2100, 3, 8'h08, 0, 0);
    serve("rerun3", 3, 14'h3100, 3, 8'h05, 1, 0);
    check_idle("rerun", 3, 8'h05);
  endtask

  task automatic test_wrap;
    for (int a = 1; a < 16; a++) load(AW'(a), 14'h1400);   // mv R1,R0
    load(0, 14'h0000);
    // Start together with a load of word 0: the new word must be issued.
    ProgLoad = 1'b1; ProgAddr = '0; ProgWord = 14'h1400;
    start_prog(15);
    ProgLoad = 1'b0;
    for (int i = 0; i < 16; i++)
      serve("wrap", AW'(i), 14'h1400, 1, 8'(i + 8'h10), (i == 15), 0);
    check_idle("wrap", 15, 8'h1F);
  endtask

  task automatic test_timeout;
    start_prog(0);
    checks++;
    if (w !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout issue: w=%b Busy=%b, expected 1 1", w, Busy);
    end
    tick;               // first WAIT cycle
`ifdef PROC_SEQ_TIMEOUT_EN
    repeat (14) tick;   // fifteenth WAIT cycle
    checks++;
    if (Busy !== 1'b1 || Error !== 1'b0) begin
      errors++;
      $display("FAIL timeout early: Busy=%b Err=%b, expected 1 0", Busy, Error);
    end
    tick;
    checks++;
    if (Error !== 1'b1 || Busy !== 1'b0 || Finished !== 1'b0 || PC !== '0 || w !== 1'b0) begin
      errors++;
      $display("FAIL timeout abort: Err=%b Busy=%b Fin=%b PC=%0d w=%b, expected 1 0 0 0 0",
               Error, Busy, Finished, PC, w);
    end
    tick;
    checks++;
    if (Error !== 1'b1 || Finished !== 1'b0) begin
      errors++;
      $display("FAIL timeout sticky: Err=%b Fin=%b, expected 1 0", Error, Finished);
    end
    start_prog(0);
    checks++;
    if (Error !== 1'b0) begin
      errors++;
      $display("FAIL timeout clear: Err=%b, expected 0", Error);
    end
    serve("after_to", 0, 14'h1400, 1, 8'h42, 1, 0);
    check_idle("after_to", 0, 8'h42);
`else
    repeat (20) tick;
    checks++;
    if (Busy !== 1'b1 || Error !== 1'b0 || w !== 1'b0 || Finished !== 1'b0) begin
      errors++;
      $display("FAIL stall: Busy=%b Err=%b w=%b Fin=%b, expected 1 0 0 0", Busy, Error, w, Finished);
    end
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    check_zero("stall_reset");
`endif
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; ProgLoad = 1'b0; Done = 1'b0;
    ProgAddr = '0; LastAddr = '0; ProgWord = '0; BusWires = '0;
    test_reset;
    test_single;
    test_program;
    test_busy_ignore;
    test_reset_mid;
    test_wrap;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
